// File: rtl/vga_input_conditioner_pkg.sv
// Shared encodings for the VGA input conditioner: screen modes, note-key indices
// and the mode-to-screen-select mapping.
package vga_input_conditioner_pkg;

  localparam int NUM_KEYS = 7;

  localparam int KEY_C = 0;
  localparam int KEY_D = 1;
  localparam int KEY_E = 2;
  localparam int KEY_F = 3;
  localparam int KEY_G = 4;
  localparam int KEY_A = 5;
  localparam int KEY_B = 6;

  typedef enum logic [1:0] {
    MODE_HOME  = 2'd0,
    MODE_FREE  = 2'd1,
    MODE_LEARN = 2'd2,
    MODE_MARY  = 2'd3
  } mode_e;

  // One-hot {mary, learn, free} select bits for vga_controller; HOME selects nothing.
  function automatic logic [2:0] screen_select(input mode_e m);
    logic [2:0] sel;
    case (m)
      MODE_HOME:  sel = 3'b000;
      MODE_FREE:  sel = 3'b001;
      MODE_LEARN: sel = 3'b010;
      MODE_MARY:  sel = 3'b100;
      default:    sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/vga_input_conditioner_debounce_sync.sv
// One-bit two-flop synchronizer followed by a hold-time debouncer; the stable level
// only moves after the synchronized input has differed for DEBOUNCE_CYCLES edges.
module debounce_sync #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter int   CNT_W           = 18,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronizer chain and debounce counter; any sample matching stable restarts the count.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_r  <= RESET_LEVEL;
      sync2_r  <= RESET_LEVEL;
      stable_r <= RESET_LEVEL;
      cnt_r    <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/vga_input_conditioner.sv
// Conditions raw keys and mode buttons for vga_controller; mode changes are held
// pending and committed only on the falling edge of vertical sync.
module vga_input_conditioner
  import vga_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                btn_home_n,
  input  logic                btn_free_n,
  input  logic                btn_learn_n,
  input  logic                btn_mary_n,
  input  logic                iVS,
  output logic [NUM_KEYS-1:0] key_out,
  output logic                free_play_button,
  output logic                learn_song_button,
  output logic                play_mary_button,
  output logic [1:0]          mode,
  output logic                key_event
);

  // Button order doubles as priority: index 0 (HOME) wins over higher indices.
  logic [3:0]          btn_raw_s;
  logic [3:0]          btn_stable_s;
  logic [3:0]          btn_press_s;
  logic [NUM_KEYS-1:0] key_stable_s;
  logic                req_any_s;
  mode_e               req_mode_s;

  logic [3:0]          btn_prev_r;
  logic [NUM_KEYS-1:0] key_prev_r;
  logic                vs_d_r;
  mode_e               mode_r;
  mode_e               pending_r;
  logic                pend_valid_r;
  logic [2:0]          sel_r;
  logic [NUM_KEYS-1:0] key_out_r;
  logic                key_event_r;

  assign btn_raw_s = {btn_mary_n, btn_learn_n, btn_free_n, btn_home_n};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_LEVEL    (1'b0)
    ) u_key (
      .iVGA_CLK(iVGA_CLK),
      .iRST_n  (iRST_n),
      .raw     (key_raw[i]),
      .stable  (key_stable_s[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_LEVEL    (1'b1)
    ) u_btn (
      .iVGA_CLK(iVGA_CLK),
      .iRST_n  (iRST_n),
      .raw     (btn_raw_s[i]),
      .stable  (btn_stable_s[i])
    );
  end

  assign btn_press_s = btn_prev_r & ~btn_stable_s;
  assign req_any_s   = |btn_press_s;

  // Priority pick among simultaneous button presses.
  always_comb begin
    req_mode_s = MODE_HOME;
    if (btn_press_s[0]) begin
      req_mode_s = MODE_HOME;
    end else if (btn_press_s[1]) begin
      req_mode_s = MODE_FREE;
    end else if (btn_press_s[2]) begin
      req_mode_s = MODE_LEARN;
    end else if (btn_press_s[3]) begin
      req_mode_s = MODE_MARY;
    end else begin
      req_mode_s = MODE_HOME;
    end
  end

  // Pending/commit state and registered outputs; a request in the vsync edge cycle defers commit.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_prev_r   <= 4'b1111;
      key_prev_r   <= '0;
      vs_d_r       <= 1'b1;
      mode_r       <= MODE_HOME;
      pending_r    <= MODE_HOME;
      pend_valid_r <= 1'b0;
      sel_r        <= 3'b000;
      key_out_r    <= '0;
      key_event_r  <= 1'b0;
    end else begin
      btn_prev_r <= btn_stable_s;
      key_prev_r <= key_stable_s;
      vs_d_r     <= iVS;
      if (req_any_s) begin
        pending_r    <= req_mode_s;
        pend_valid_r <= 1'b1;
      end else if (vs_d_r && !iVS && pend_valid_r) begin
        mode_r       <= pending_r;
        pend_valid_r <= 1'b0;
      end
      sel_r <= screen_select(mode_r);
      if (mode_r != MODE_HOME) begin
        key_out_r   <= key_stable_s;
        key_event_r <= |(key_stable_s & ~key_prev_r);
      end else begin
        key_out_r   <= '0;
        key_event_r <= 1'b0;
      end
    end
  end

  assign key_out           = key_out_r;
  assign key_event         = key_event_r;
  assign mode              = mode_r;
  assign free_play_button  = sel_r[0];
  assign learn_song_button = sel_r[1];
  assign play_mary_button  = sel_r[2];

endmodule

// File: doc/vga_input_conditioner.md
Name: vga_input_conditioner

Overview:
- Upstream stage of vga_controller; runs on the same pixel clock.
- Synchronizes and debounces the seven raw note-key inputs and four raw mode pushbuttons.
- Runs a screen-mode state machine and drives vga_controller's c/d/e/f/g/a/b and free_play_button/learn_song_button/play_mary_button inputs.
- Mode changes are committed only at the start of vertical sync, so a frame never shows two images.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles an input must hold a new level before it is accepted (10 ms at 25 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- iVGA_CLK  in  1  pixel clock.
- iRST_n  in  1  reset.
- key_raw  in  7  raw note keys, active-high; bit0=C, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B.
- btn_home_n  in  1  raw home pushbutton, active-low.
- btn_free_n  in  1  raw free-play pushbutton, active-low.
- btn_learn_n  in  1  raw learn-song pushbutton, active-low.
- btn_mary_n  in  1  raw play-mary pushbutton, active-low.
- iVS  in  1  vertical sync from video_sync_generator, active-low, already in the iVGA_CLK domain.
- key_out  out  7  debounced, mode-gated note keys; same bit order as key_raw.
- free_play_button  out  1  screen select bit0.
- learn_song_button  out  1  screen select bit1.
- play_mary_button  out  1  screen select bit2.
- mode  out  2  committed mode: 0 HOME, 1 FREE, 2 LEARN, 3 MARY.
- key_event  out  1  one-cycle pulse on any debounced key press (0->1) while mode != HOME.

Behaviour:
- Reset iRST_n is asynchronous, active-low; clock is iVGA_CLK.
- Reset values:
  - all outputs 0;
  - mode = HOME;
  - pending-valid = 0;
  - all synchronizer flops and stable levels = released (keys 0, buttons 1 raw);
  - all counters 0.
- Synchronization: every raw input passes through a 2-flop synchronizer.
- Debounce, per input, one counter each:
  - If synced == stable, counter clears to 0.
  - Otherwise counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and synced still differs, stable <= synced and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never changes stable.
  - Latency from a held raw change to the stable change is exactly DEBOUNCE_CYCLES+2 cycles.
- Button request: a 1-cycle request fires when a button's stable level goes 1->0 (press). Release generates nothing.
- Request priority, when several fire in the same cycle: HOME > FREE > LEARN > MARY. The winner is written to the pending register and pending-valid is set.
- A later request before commit overwrites the pending value (last press wins).
- A request equal to the committed mode still sets pending; committing it is a no-op.
- Commit:
  - iVS is registered once (vs_d).
  - A falling edge (vs_d=1, iVS=0) with pending-valid=1 loads mode <= pending and clears pending-valid in the same cycle.
  - If a request arrives in the edge cycle, the new request wins and stays pending for the next frame; it is not committed in that cycle.
- Screen select outputs, registered from mode; update one cycle after mode changes:
  - HOME -> 000;
  - FREE -> free_play_button=1;
  - LEARN -> learn_song_button=1;
  - MARY -> play_mary_button=1.
  - Exactly one bit is set outside HOME.
- key_out:
  - registered; equals the stable key levels when mode != HOME, else 0;
  - gating follows the committed mode;
  - simultaneous keys are passed through unmodified; vga_controller resolves priority.
- key_event: registered pulse equal to OR over bits of (stable_key & ~stable_key_prev), gated by mode != HOME.
- Reset asserted mid-debounce or with a pending request: everything returns to reset values immediately; no commit occurs after reset release until a new press completes debounce.

Decomposition:
- Shared package holds:
  - mode encodings MODE_HOME/FREE/LEARN/MARY (2-bit);
  - key bit indices KEY_C..KEY_B;
  - NUM_KEYS=7.
- One sub-module, debounce_sync: 2-flop synchronizer plus counter for one bit.
  - Parameters: DEBOUNCE_CYCLES, CNT_W, RESET_LEVEL.
  - Instantiated 11 times.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset, then btn_free_n low for 10 cycles with iVS high -> mode stays 0. Drive iVS 1->0 -> mode=1 on that edge; free_play_button=1 one cycle later.
- Mode FREE, key_raw[2] high for 3 cycles then low -> key_out stays 0. Hold high 6 cycles -> key_out=7'b0000100 and key_event pulses once, 7 cycles after the raw rise.
- Mode HOME, key_raw=7'h7F held -> key_out=0 and key_event=0 throughout.
- btn_learn_n and btn_mary_n pressed in the same cycle, then vsync edge -> mode=2, select=010.
- Press MARY, then HOME before the next vsync edge -> commit yields mode=0, select=000. A further vsync edge with no press -> no change.
- Pending MARY, assert iRST_n low for 2 cycles, release, then vsync edge -> mode=0, all outputs 0.
